// File: rtl/pipelined_cla_addsub.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake and flags.
// Optional macro CLA_SATURATE_EN clamps F to the signed limit when OF is set.
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 16, // even, >= 4
    parameter int unsigned GROUP = 4   // must divide WIDTH/2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic             MODE,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             CO,
    output logic             OF,
    output logic             ZF,
    output logic             SF
);

    localparam int unsigned H  = WIDTH / 2;
    localparam int unsigned NG = H / GROUP;

    // Half-width CLA: returns {carry_out, sum}. Group G/P collapse feeds the group carry chain;
    // bit carries inside each group are derived from that group's incoming carry.
    function automatic logic [H:0] cla_half(input logic [H-1:0] a, input logic [H-1:0] b,
                                            input logic cin);
        logic [H-1:0]  g;
        logic [H-1:0]  p;
        logic [H-1:0]  c;
        logic [NG:0]   gc;
        logic          gg;
        logic          gp;
        g     = a & b;
        p     = a | b;
        gc[0] = cin;
        for (int k = 0; k < int'(NG); k++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < int'(GROUP); j++) begin
                gg = g[k*GROUP+j] | (p[k*GROUP+j] & gg);
                gp = gp & p[k*GROUP+j];
            end
            gc[k+1] = gg | (gp & gc[k]);
        end
        for (int i = 0; i < int'(H); i++) begin
            if ((i % int'(GROUP)) == 0) begin
                c[i] = gc[i/GROUP];
            end else begin
                c[i] = g[i-1] | (p[i-1] & c[i-1]);
            end
        end
        return {gc[NG], a ^ b ^ c};
    endfunction

    // Stage 1 state
    logic         s1_valid_q, s1_valid_d;
    logic [H-1:0] s1_sum_lo_q, s1_sum_lo_d;
    logic         s1_carry_q, s1_carry_d;
    logic [H-1:0] s1_a_hi_q, s1_a_hi_d;
    logic [H-1:0] s1_b_hi_q, s1_b_hi_d;
    logic         s1_mode_q, s1_mode_d;

    // Stage 2 (output) state
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             co_q, co_d;
    logic             of_q, of_d;
    logic             zf_q, zf_d;
    logic             sf_q, sf_d;

    logic             accept;
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [H:0]       lo_res;
    logic [H:0]       hi_res;
    logic             raw_carry;
    logic             carry_into_msb;
    logic             ovf;
    logic [WIDTH-1:0] f_wrap;
    logic [WIDTH-1:0] f_final;

    assign advance  = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | advance;
    assign accept   = in_valid & in_ready;

    assign b_eff   = MODE ? ~B : B;
    assign cin_eff = MODE ? ~C0 : C0;
    assign lo_res  = cla_half(A[H-1:0], b_eff[H-1:0], cin_eff);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_lo_d = s1_sum_lo_q;
        s1_carry_d  = s1_carry_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_b_hi_d   = s1_b_hi_q;
        s1_mode_d   = s1_mode_q;
        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_sum_lo_d = lo_res[H-1:0];
            s1_carry_d  = lo_res[H];
            s1_a_hi_d   = A[WIDTH-1:H];
            s1_b_hi_d   = b_eff[WIDTH-1:H];
            s1_mode_d   = MODE;
        end else if (advance) begin
            s1_valid_d  = 1'b0;
        end
    end

    assign hi_res    = cla_half(s1_a_hi_q, s1_b_hi_q, s1_carry_q);
    assign raw_carry = hi_res[H];
    assign f_wrap    = {hi_res[H-1:0], s1_sum_lo_q};
    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
    assign carry_into_msb = s1_a_hi_q[H-1] ^ s1_b_hi_q[H-1] ^ hi_res[H-1];
    assign ovf            = carry_into_msb ^ raw_carry;

`ifdef CLA_SATURATE_EN
    // Overflow implies A and B' share a sign, so A's MSB gives the clamp direction.
    always_comb begin
        f_final = f_wrap;
        if (ovf) begin
            f_final = s1_a_hi_q[H-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign f_final = f_wrap;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        f_d         = f_q;
        co_d        = co_q;
        of_d        = of_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        if (advance) begin
            out_valid_d = 1'b1;
            f_d         = f_final;
            co_d        = s1_mode_q ? ~raw_carry : raw_carry;
            of_d        = ovf;
            zf_d        = (f_final == '0);
            sf_d        = f_final[WIDTH-1];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_lo_q <= '0;
            s1_carry_q  <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_b_hi_q   <= '0;
            s1_mode_q   <= 1'b0;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            co_q        <= 1'b0;
            of_q        <= 1'b0;
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_lo_q <= s1_sum_lo_d;
            s1_carry_q  <= s1_carry_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            s1_mode_q   <= s1_mode_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            co_q        <= co_d;
            of_q        <= of_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign F         = f_q;
    assign CO        = co_q;
    assign OF        = of_q;
    assign ZF        = zf_q;
    assign SF        = sf_q;

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor. Successor to the team's fixed 8-bit combinational CLA.
- Stage 1 adds the low half of the operands with group generate/propagate lookahead. Stage 2 adds the high half using the registered low-half carry.
- Valid/ready handshake on both sides; status flags produced alongside the result.
- Sits between the register-file read port and the writeback mux of the lab datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be even and >= 4.
- GROUP, 4, lookahead group size in bits; must divide WIDTH/2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- C0  in  1  carry-in (ADD) / borrow-in (SUB).
- MODE  in  1  0 = ADD, 1 = SUB.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- F  out  WIDTH  result.
- CO  out  1  carry-out (ADD) / borrow-out (SUB).
- OF  out  1  signed overflow.
- ZF  out  1  F == 0.
- SF  out  1  F[WIDTH-1].

Behaviour:
- Reset: one clock domain. rst_n is asynchronous and active-low; it clears all valid and data registers immediately. Outputs after reset: out_valid=0, F=0, CO=0, OF=0, ZF=0, SF=0. in_ready=1 once rst_n is high.
- Arithmetic:
  - Effective B' = MODE ? ~B : B.
  - Effective cin = MODE ? ~C0 : C0.
  - ADD computes A+B+C0; SUB computes A-B-C0.
  - Per bit: G = A&B', P = A|B'. Group carries C[i+1] = G[i] | (P[i] & C[i]). Sum bit = A^B'^C.
  - Raw carry = carry out of bit WIDTH-1. CO = raw carry for ADD, ~raw carry for SUB.
  - OF = carry into MSB XOR carry out of MSB.
  - ZF and SF are computed from the final F, after saturation if enabled.
- Stage 1, on accept (in_valid & in_ready):
  - Registers low-half sum, low-half carry-out, high halves of A and B', and MODE.
  - Sets s1_valid.
- Stage 2, on advance:
  - Computes the high half with the registered carry and forms the flags.
  - Registers F, CO, OF, ZF, SF; sets out_valid.
- Latency and throughput: exactly 2 cycles from accept to out_valid with no stall. Throughput is 1 per cycle.
- Handshake:
  - Stage 2 advances when s1_valid & (!out_valid | out_ready).
  - in_ready = !s1_valid | stage-2 advance.
  - On handshake (out_valid & out_ready) with no new data from stage 1, out_valid clears.
  - While out_valid & !out_ready, F and all flags hold stable.
- Simultaneous events: output handshake and stage-2 advance in the same cycle replaces the output register; out_valid stays 1. Accept and stage-1 advance in the same cycle replaces stage 1.
- Stall: both stages full and out_ready=0 gives in_ready=0. A input offered while in_ready=0 is ignored.
- Wrap-around: ADD result is modulo 2^WIDTH and CO reports the overflow. SUB underflow wraps, with CO=1 for borrow.
- Reset mid-operation discards all in-flight data; no output is produced for it.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- Defined: when OF=1, F is clamped. The positive limit is 0111…1 if operand A's MSB is 0; otherwise the negative limit 1000…0. OF still reports 1; CO is unchanged.
- Undefined: F always wraps; the clamp logic is absent.

Test Plan (WIDTH=16):
- Reset: hold rst_n=0, then release -> out_valid=0, F=0, all flags 0, in_ready=1.
- ADD: A=0x00FF, B=0x0001, C0=0, MODE=0 -> 2 cycles later F=0x0100, CO=0, OF=0, ZF=0, SF=0. Confirms the low-to-high carry crossing the stage boundary.
- Wrap and borrow:
  - ADD A=0xFFFF, B=0x0001, C0=0 -> F=0x0000, CO=1, ZF=1.
  - SUB A=0x0000, B=0x0001, C0=0 -> F=0xFFFF, CO=1, SF=1.
- Overflow: ADD A=0x7FFF, B=0x0001 -> OF=1. F=0x8000 without the macro; F=0x7FFF with CLA_SATURATE_EN.
- Back-pressure:
  - Stream 4 operations back-to-back with out_ready low for 3 cycles -> in_ready drops after 2 accepts, F holds, no result is lost or duplicated, order is preserved.
  - Then set out_ready=1 -> one result per cycle.
- Reset mid-stream: assert rst_n low while both stages are valid -> out_valid=0 immediately (asynchronously); no stale result appears after release.
